// File: rtl/sll_iter.sv
`default_nettype none
// ============================================================================
//  Module   : sll_iter
//  Purpose  : Multi-cycle logical left shifter. One binary-weighted stage is
//             applied per clock (largest stage first), with a start/ready
//             handshake and a sticky flag for 1 bits shifted out the top.
//  Revision : 1.0 - initial release
// ============================================================================
module sll_iter #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   ctrl_start,
    input  logic [DATA_WIDTH-1:0]  data_A,
    input  logic [SHAMT_WIDTH-1:0] data_shamt,
    output logic [DATA_WIDTH-1:0]  data_result,
    output logic                   data_resultRDY,
    output logic                   busy,
    output logic                   data_lost
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    localparam int                 c_CNT_W = (SHAMT_WIDTH > 1) ? $clog2(SHAMT_WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(SHAMT_WIDTH - 1);

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [c_CNT_W-1:0]     r_count;
    logic [DATA_WIDTH-1:0]  r_work;
    // Shift amount is consumed MSB-first: the register shifts left each stage
    // so the bit governing the current stage always sits at the top.
    logic [SHAMT_WIDTH-1:0] r_shamt;
    logic                   r_lost;
    logic                   r_rdy;
    logic                   r_busy;

    logic [DATA_WIDTH-1:0]  w_stage_res  [SHAMT_WIDTH];
    logic [SHAMT_WIDTH-1:0] w_stage_drop;
    logic [DATA_WIDTH-1:0]  w_sel_res;
    logic                   w_sel_drop;

    // Each stage is a fixed shift; the bits it would discard are its top bits.
    generate
        for (genvar i = 0; i < SHAMT_WIDTH; i++) begin : g_stage
            localparam int c_AMT = 2 ** (SHAMT_WIDTH - 1 - i);
            assign w_stage_res[i]  = r_work << c_AMT;
            assign w_stage_drop[i] = |r_work[DATA_WIDTH-1 -: c_AMT];
        end
    endgenerate

    // Pick the stage selected by the stage counter.
    always_comb begin
        w_sel_res  = r_work;
        w_sel_drop = 1'b0;
        for (int i = 0; i < SHAMT_WIDTH; i++) begin
            if (r_count == c_CNT_W'(i)) begin
                w_sel_res  = w_stage_res[i];
                w_sel_drop = w_stage_drop[i];
            end
        end
    end

    // Next-state logic; a start in any state (re)launches an operation.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (ctrl_start) w_state_nxt = c_SHIFT;
            end
            c_SHIFT: begin
                if (ctrl_start)            w_state_nxt = c_SHIFT;
                else if (r_count == c_LAST) w_state_nxt = c_DONE;
            end
            c_DONE: begin
                w_state_nxt = ctrl_start ? c_SHIFT : c_IDLE;
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) r_state <= c_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Datapath and registered status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
            r_work  <= '0;
            r_shamt <= '0;
            r_lost  <= 1'b0;
            r_rdy   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == c_SHIFT);
            r_rdy  <= (w_state_nxt == c_DONE);
            if (ctrl_start) begin
                r_work  <= data_A;
                r_shamt <= data_shamt;
                r_count <= '0;
                r_lost  <= 1'b0;
            end else if (r_state == c_SHIFT) begin
                if (r_shamt[SHAMT_WIDTH-1]) begin
                    r_work <= w_sel_res;
                    r_lost <= r_lost | w_sel_drop;
                end
                r_shamt <= r_shamt << 1;
                r_count <= (r_count == c_LAST) ? '0 : r_count + c_CNT_W'(1);
            end
        end
    end

    assign data_result    = r_work;
    assign data_resultRDY = r_rdy;
    assign busy           = r_busy;
    assign data_lost      = r_lost;

endmodule
`default_nettype wire

// File: tb/tb_sll_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sll_iter
//  Purpose  : Scoreboard bench for sll_iter. The driver pushes hand-computed
//             results with their expected RDY cycle; a monitor pops and
//             compares whenever RDY is seen.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sll_iter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_start = 1'b0;
    logic [31:0] data_A = '0;
    logic [4:0]  data_shamt = '0;
    logic [31:0] data_result;
    logic        data_resultRDY;
    logic        busy;
    logic        data_lost;

    sll_iter #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_start     (ctrl_start),
        .data_A         (data_A),
        .data_shamt     (data_shamt),
        .data_result    (data_result),
        .data_resultRDY (data_resultRDY),
        .busy           (busy),
        .data_lost      (data_lost)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic        lost;
        int          at;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: compare on every RDY, flag pulse width, strays and timeouts.
    logic prev_rdy = 1'b0;
    always @(negedge clock) begin
        exp_t e;
        if (data_resultRDY === 1'b1) begin
            chk("rdy_pulse_width", {31'b0, prev_rdy}, 32'd0);
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rdy actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                e = sbq.pop_front();
                chk("rdy_cycle", cyc, e.at);
                chk("result", data_result, e.res);
                chk("lost", {31'b0, data_lost}, {31'b0, e.lost});
                chk("busy_at_rdy", {31'b0, busy}, 32'd0);
            end
        end else if (sbq.size() > 0 && cyc > sbq[0].at) begin
            checks++;
            errors++;
            $display("FAIL rdy_timeout actual=none required_cycle=%0d", sbq[0].at);
            void'(sbq.pop_front());
        end
        prev_rdy = (data_resultRDY === 1'b1);
    end

    // Called at a negedge; the following posedge is the start edge.
    task automatic issue(input logic [31:0] a, input logic [4:0] s, input bit expect_it,
                         input logic [31:0] res, input logic lost);
        exp_t e;
        ctrl_start = 1'b1;
        data_A     = a;
        data_shamt = s;
        if (expect_it) begin
            e.res  = res;
            e.lost = lost;
            e.at   = cyc + 6;
            sbq.push_back(e);
        end
        @(negedge clock);
        ctrl_start = 1'b0;
        data_A     = $urandom;
        data_shamt = 5'($urandom);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && sbq.size() > 0; i++) @(negedge clock);
        @(negedge clock);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_result"}, data_result, 32'd0);
        chk({tag, "_rdy"},    {31'b0, data_resultRDY}, 32'd0);
        chk({tag, "_busy"},   {31'b0, busy}, 32'd0);
        chk({tag, "_lost"},   {31'b0, data_lost}, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        chk_all_zero("reset");
        reset = 1'b0;
        @(negedge clock);

        // Largest shift, busy for exactly five cycles.
        issue(32'h0000_0001, 5'd31, 1'b1, 32'h8000_0000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("busy_window", {31'b0, busy}, 32'd1);
            @(negedge clock);
        end
        wait_idle();

        // Lost-bit detection, both ways.
        issue(32'hFFFF_FFFF, 5'd4, 1'b1, 32'hFFFF_FFF0, 1'b1);
        wait_idle();
        issue(32'h0F00_0000, 5'd4, 1'b1, 32'hF000_0000, 1'b0);
        wait_idle();

        // Zero shift still takes the full latency.
        issue(32'h1234_5678, 5'd0, 1'b1, 32'h1234_5678, 1'b0);
        wait_idle();

        // Restart while busy: only the second operation reports.
        issue(32'h0000_0001, 5'd3, 1'b0, 32'h0, 1'b0);
        @(negedge clock);
        issue(32'h0000_0002, 5'd8, 1'b1, 32'h0000_0200, 1'b0);
        wait_idle();

        // Reset mid-operation abandons it.
        issue(32'hAAAA_AAAA, 5'd1, 1'b0, 32'h0, 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk_all_zero("midreset");
        repeat (8) @(negedge clock);
        issue(32'hAAAA_AAAA, 5'd1, 1'b1, 32'h5555_5554, 1'b1);
        wait_idle();

        // Back-to-back: new start on the RDY cycle.
        issue(32'h0000_0005, 5'd2, 1'b1, 32'h0000_0014, 1'b0);
        repeat (5) @(negedge clock);
        issue(32'h0000_0003, 5'd30, 1'b1, 32'hC000_0000, 1'b0);
        wait_idle();
        repeat (3) @(negedge clock);

        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover actual=%0d required=0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
